pll_drp_ctrl: RTL and testbench
===============================

# pll_drp_ctrl

Dynamic-reconfiguration sequencer for the PLL_ADV clock generator. A host loads a short list of read-modify-write operations into a small FIFO and pulses `go`. The controller then:
- holds the PLL in reset,
- applies each operation over the PLL's DRP port,
- releases reset and waits for `LOCKED`, reporting completion or error.

It sits beside the PLL in the clock top level and drives the PLL's `RST`, `DADDR`, `DI`, `DEN` and `DWE` pins, which are currently tied off.

## Interface
- `DEPTH`, 4: operation FIFO entries; power of two, 2..16.
- `RST_HOLD`, 8: cycles `pll_rst` is held before the first DRP access; ≥1.
- `DRDY_TIMEOUT`, 64: maximum cycles from `drp_den` to `drp_drdy`.
- `LOCK_TIMEOUT`, 65535: maximum cycles from `pll_rst` release to `pll_locked`.
- `clk_in` in 1: sole clock; also drives the PLL `DCLK`.
- `rst` in 1: asynchronous, active-high reset.
- `op_valid` in 1: operation push request.
- `op_ready` out 1: FIFO can accept an operation; low when full or `busy`.
- `op_addr` in 5: DRP register address.
- `op_mask` in 16: 1 = keep the existing bit, 0 = replace it from `op_data`.
- `op_data` in 16: new bit values.
- `go` in 1: single-cycle start request.
- `busy` out 1: sequence in progress.
- `done` out 1: single-cycle end-of-sequence pulse.
- `err` out 2: 0 = ok, 1 = DRDY timeout, 2 = lock timeout.
- `drp_daddr` out 5, `drp_di` out 16, `drp_den` out 1, `drp_dwe` out 1: DRP drive.
- `drp_do` in 16, `drp_drdy` in 1: DRP return.
- `pll_rst` out 1: to the PLL `RST` pin.
- `pll_locked` in 1: from the PLL `LOCKED` pin; asynchronous, double-flop synchronised internally.

## Operation
- Push: an operation is accepted when `op_valid & op_ready` at a rising edge. Entries are stored in order.
- Start: `go` is honoured only in IDLE. `go` while `busy` is ignored.
- States: IDLE → HOLD → RD_REQ → RD_WAIT → WR_REQ → WR_WAIT → (next entry ? RD_REQ : LOCK_WAIT) → FINISH → IDLE.
- IDLE: `busy`=0, `pll_rst`=0, DRP outputs 0.
- HOLD: `pll_rst`=1 for `RST_HOLD` cycles. With an empty FIFO, HOLD goes straight to LOCK_WAIT, giving a plain PLL reset cycle.
- RD_REQ: `drp_daddr`=head `op_addr`, `drp_den`=1, `drp_dwe`=0 for one cycle.
- RD_WAIT: on `drp_drdy`, capture `w = (drp_do & op_mask) | (op_data & ~op_mask)`.
- WR_REQ: `drp_di`=`w`, `drp_den`=1, `drp_dwe`=1 for one cycle.
- WR_WAIT: on `drp_drdy`, pop the head entry.
- LOCK_WAIT: `pll_rst`=0; wait for synchronised `pll_locked`=1.
- FINISH: `done`=1 for one cycle; `err` is updated in the same cycle and held until the next accepted `go`.
- `busy`=1 in every state except IDLE.
- DRDY timeout: abort from RD_WAIT or WR_WAIT when the wait reaches `DRDY_TIMEOUT` cycles. Flush the FIFO, drive `pll_rst`=0, go to FINISH with `err`=1. No lock wait is performed.
- Lock timeout: reaching `LOCK_TIMEOUT` cycles in LOCK_WAIT → FINISH with `err`=2.
- `drp_drdy` outside the WAIT states is ignored.
- `pll_locked` is ignored outside LOCK_WAIT.

## Timing
- Reset values: `op_ready`=1, `busy`=0, `done`=0, `err`=0, `pll_rst`=0, `drp_*` outputs=0. FIFO empty, state IDLE.
- All outputs are registered.
- `go` at edge N → `busy`=1 and `pll_rst`=1 from edge N+1.
- First `drp_den` occurs at edge N+1+`RST_HOLD`.
- `drp_den` is a single-cycle pulse. `drp_daddr`, `drp_di` and `drp_dwe` are held from the `drp_den` cycle until `drp_drdy` is sampled.
- `drp_drdy` is accepted from the cycle after `drp_den`, so minimum DRP latency is 1.
- Minimum cost per operation is 4 cycles: RD_REQ, RD_WAIT, WR_REQ, WR_WAIT.
- LOCK_WAIT counting starts at the first cycle with `pll_rst`=0. Synchroniser latency (2 cycles) is included in the timeout.
- `rst` mid-sequence returns the block to reset values immediately (asynchronously) and discards FIFO contents. `pll_rst` drops to 0 at that point.
- A push in the same cycle as an accepted `go` is not possible: `op_ready` falls with `busy`.

## Test plan
- Empty FIFO, `go`, `RST_HOLD`=8, `pll_locked` rises 20 cycles after release → 8 `pll_rst` cycles, no `drp_den`, `done` pulse with `err`=0.
- One op (addr 0x08, mask 0xFF00, data 0x1234), DRP model returns 0xABCD with 3-cycle DRDY → read at 0x08, then write `drp_di`=0xAB34 with `drp_dwe`=1, then `done` with `err`=0.
- Fill 4 ops: `op_ready` drops after the 4th push. Run `go` → four read/write pairs in push order; `op_ready` returns to 1 after `done`.
- DRP model never asserts DRDY on the 2nd op → abort after 64 cycles, `err`=1, `pll_rst`=0, FIFO empty, no lock wait.
- `pll_locked` held 0, `LOCK_TIMEOUT`=100 → `done` at 100 cycles after release with `err`=2. A second `go` pulsed while `busy` has no effect.
- Assert `rst` during RD_WAIT → all outputs return to reset values at once; a subsequent `go` with an empty FIFO completes normally.

Source files
------------

// File: rtl/pll_drp_ctrl.sv
`default_nettype none
// ============================================================================
// pll_drp_ctrl : PLL_ADV reconfiguration sequencer - queues read-modify-write
//                operations, holds the PLL in reset, applies them over DRP,
//                then releases reset and waits for lock.
// Revision     : 1.0
// ============================================================================
module pll_drp_ctrl #(
   parameter int DEPTH        = 4,
   parameter int RST_HOLD     = 8,
   parameter int DRDY_TIMEOUT = 64,
   parameter int LOCK_TIMEOUT = 65535
) (
   input  logic        clk_in,
   input  logic        rst,
   input  logic        op_valid,
   output logic        op_ready,
   input  logic [4:0]  op_addr,
   input  logic [15:0] op_mask,
   input  logic [15:0] op_data,
   input  logic        go,
   output logic        busy,
   output logic        done,
   output logic [1:0]  err,
   output logic [4:0]  drp_daddr,
   output logic [15:0] drp_di,
   output logic        drp_den,
   output logic        drp_dwe,
   input  logic [15:0] drp_do,
   input  logic        drp_drdy,
   output logic        pll_rst,
   input  logic        pll_locked
);
   localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int T1   = (LOCK_TIMEOUT > DRDY_TIMEOUT) ? LOCK_TIMEOUT : DRDY_TIMEOUT;
   localparam int TMAX = (T1 > RST_HOLD) ? T1 : RST_HOLD;
   localparam int CW   = $clog2(TMAX + 1);
   localparam logic [PW:0] FULL = (PW+1)'(DEPTH);
   localparam logic [PW:0] ONE  = (PW+1)'(1);

   typedef enum logic [2:0] {
      S_IDLE, S_HOLD, S_RD_REQ, S_RD_WAIT, S_WR_REQ, S_WR_WAIT, S_LOCK_WAIT, S_FINISH
   } state_t;

   state_t        state;
   logic [4:0]    addr_mem [DEPTH];
   logic [15:0]   mask_mem [DEPTH];
   logic [15:0]   data_mem [DEPTH];
   logic [PW-1:0] wr_ptr, rd_ptr, nxt_ptr;
   logic [PW:0]   count, count_nxt;
   logic [CW-1:0] cnt;
   logic          push, pop, drdy_to, wait_st;
   logic          locked_meta, locked_sync;
   logic [15:0]   rmw;

   assign push      = op_valid & op_ready;
   assign wait_st   = (state == S_RD_WAIT) || (state == S_WR_WAIT);
   assign drdy_to   = wait_st & ~drp_drdy & (cnt == CW'(DRDY_TIMEOUT));
   assign pop       = (state == S_WR_WAIT) & drp_drdy;
   assign count_nxt = count + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};
   assign nxt_ptr   = rd_ptr + PW'(1);
   assign rmw       = (drp_do & mask_mem[rd_ptr]) | (data_mem[rd_ptr] & ~mask_mem[rd_ptr]);

   always_ff @(posedge clk_in) begin
      if (push) begin
         addr_mem[wr_ptr] <= op_addr;
         mask_mem[wr_ptr] <= op_mask;
         data_mem[wr_ptr] <= op_data;
      end
   end

   // A DRDY timeout discards every queued operation, not just the failing one.
   always_ff @(posedge clk_in or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (drdy_to) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PW'(1);
         if (pop)  rd_ptr <= nxt_ptr;
         count <= count_nxt;
      end
   end

   always_ff @(posedge clk_in or posedge rst) begin
      if (rst) begin
         locked_meta <= 1'b0;
         locked_sync <= 1'b0;
      end else begin
         locked_meta <= pll_locked;
         locked_sync <= locked_meta;
      end
   end

   always_ff @(posedge clk_in or posedge rst) begin
      if (rst) begin
         state     <= S_IDLE;
         op_ready  <= 1'b1;
         busy      <= 1'b0;
         done      <= 1'b0;
         err       <= 2'd0;
         pll_rst   <= 1'b0;
         drp_daddr <= 5'd0;
         drp_di    <= 16'd0;
         drp_den   <= 1'b0;
         drp_dwe   <= 1'b0;
         cnt       <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (go) begin
                  state    <= S_HOLD;
                  busy     <= 1'b1;
                  pll_rst  <= 1'b1;
                  err      <= 2'd0;
                  op_ready <= 1'b0;
                  cnt      <= '0;
               end else begin
                  op_ready <= (count_nxt != FULL);
               end
            end
            S_HOLD: begin
               if (cnt == CW'(RST_HOLD - 1)) begin
                  if (count != '0) begin
                     state     <= S_RD_REQ;
                     drp_daddr <= addr_mem[rd_ptr];
                     drp_den   <= 1'b1;
                     drp_dwe   <= 1'b0;
                  end else begin
                     state   <= S_LOCK_WAIT;
                     pll_rst <= 1'b0;
                     cnt     <= CW'(1);
                  end
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            S_RD_REQ, S_WR_REQ: begin
               drp_den <= 1'b0;
               cnt     <= CW'(1);
               state   <= (state == S_RD_REQ) ? S_RD_WAIT : S_WR_WAIT;
            end
            S_RD_WAIT, S_WR_WAIT: begin
               if (drp_drdy && state == S_RD_WAIT) begin
                  state   <= S_WR_REQ;
                  drp_di  <= rmw;
                  drp_den <= 1'b1;
                  drp_dwe <= 1'b1;
               end else if (drp_drdy) begin
                  drp_di  <= 16'd0;
                  drp_dwe <= 1'b0;
                  if (count != ONE) begin
                     state     <= S_RD_REQ;
                     drp_daddr <= addr_mem[nxt_ptr];
                     drp_den   <= 1'b1;
                  end else begin
                     state     <= S_LOCK_WAIT;
                     drp_daddr <= 5'd0;
                     pll_rst   <= 1'b0;
                     cnt       <= CW'(1);
                  end
               end else if (drdy_to) begin
                  // Abort skips the lock wait; the PLL is simply let out of reset.
                  state     <= S_FINISH;
                  done      <= 1'b1;
                  err       <= 2'd1;
                  pll_rst   <= 1'b0;
                  drp_daddr <= 5'd0;
                  drp_di    <= 16'd0;
                  drp_dwe   <= 1'b0;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            S_LOCK_WAIT: begin
               if (locked_sync) begin
                  state <= S_FINISH;
                  done  <= 1'b1;
                  err   <= 2'd0;
               end else if (cnt == CW'(LOCK_TIMEOUT)) begin
                  state <= S_FINISH;
                  done  <= 1'b1;
                  err   <= 2'd2;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            S_FINISH: begin
               state    <= S_IDLE;
               busy     <= 1'b0;
               op_ready <= (count != FULL);
            end
            default: state <= S_IDLE;
         endcase
      end
   end
endmodule
`default_nettype wire

// File: tb/tb_pll_drp_ctrl.sv
`default_nettype none
// ============================================================================
// tb_pll_drp_ctrl : directed bench with a DRP register model, a PLL lock model
//                   and a scoreboard of expected DRP accesses.
// Revision        : 1.0
// ============================================================================
module tb_pll_drp_ctrl;
   localparam int RST_HOLD = 8;
   localparam int DRDY_TO  = 64;
   localparam int LOCK_TO  = 100;

   typedef struct {
      bit          we;
      logic [4:0]  addr;
      logic [15:0] data;
   } sb_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, op_valid, go;
   logic [4:0]  op_addr;
   logic [15:0] op_mask, op_data;
   logic        op_ready, busy, done, drp_den, drp_dwe, pll_rst;
   logic [1:0]  err;
   logic [4:0]  drp_daddr;
   logic [15:0] drp_di;
   logic [15:0] drp_do     = 16'h0;
   logic        drp_drdy   = 1'b0;
   logic        pll_locked = 1'b0;

   pll_drp_ctrl #(.DEPTH(4), .RST_HOLD(RST_HOLD), .DRDY_TIMEOUT(DRDY_TO), .LOCK_TIMEOUT(LOCK_TO)) dut (
      .clk_in(clk), .rst(rst), .op_valid(op_valid), .op_ready(op_ready), .op_addr(op_addr),
      .op_mask(op_mask), .op_data(op_data), .go(go), .busy(busy), .done(done), .err(err),
      .drp_daddr(drp_daddr), .drp_di(drp_di), .drp_den(drp_den), .drp_dwe(drp_dwe),
      .drp_do(drp_do), .drp_drdy(drp_drdy), .pll_rst(pll_rst), .pll_locked(pll_locked)
   );

   int checks = 0, failures = 0, cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // DRP register model and responder
   sb_t         sb[$];
   sb_t         exp_e;
   logic [15:0] drp_mem [32];
   logic [15:0] shadow  [32];
   bit          mem_init = 0, pend = 0, p_we = 0;
   int          left = 0, den_count = 0, drdy_lat = 1, stall_at = -1;
   int          den_cyc [512];
   logic [4:0]  p_addr = 5'd0, last_wr_addr = 5'd0;
   logic [15:0] p_di = 16'h0, last_wr_data = 16'h0;

   always @(negedge clk) begin
      if (rst) begin
         pend     = 0;
         drp_drdy = 1'b0;
         drp_do   = 16'h0;
         if (!mem_init) begin
            for (int i = 0; i < 32; i++) drp_mem[i] = 16'(i * 16'h0731) ^ 16'h5A5A;
            drp_mem[8] = 16'hABCD;
            mem_init   = 1;
         end
      end else begin
         drp_drdy = 1'b0;
         if (pend) begin
            left--;
            if (left == 0) begin
               pend = 0;
               chk("drp_addr_hold", 32'(drp_daddr), 32'(p_addr));
               chk("drp_dwe_hold", 32'(drp_dwe), 32'(p_we));
               drp_drdy = 1'b1;
               if (p_we) begin
                  drp_mem[p_addr] = p_di;
                  last_wr_addr    = p_addr;
                  last_wr_data    = p_di;
                  drp_do          = 16'h0;
               end else begin
                  drp_do = drp_mem[p_addr];
               end
            end
         end
         if (drp_den) begin
            den_cyc[den_count % 512] = cyc;
            chk("drp_access_expected", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
               exp_e = sb.pop_front();
               chk("drp_dwe", 32'(drp_dwe), 32'(exp_e.we));
               chk("drp_daddr", 32'(drp_daddr), 32'(exp_e.addr));
               if (exp_e.we) chk("drp_di", 32'(drp_di), 32'(exp_e.data));
            end
            if (den_count != stall_at) begin
               pend   = 1;
               left   = drdy_lat;
               p_we   = drp_dwe;
               p_addr = drp_daddr;
               p_di   = drp_di;
            end
            den_count++;
         end
      end
   end

   // PLL lock model and output monitor
   int   prst_cnt = 0, done_cnt = 0, done_cyc = 0, rst_fall_cyc = 0, lk = 0;
   logic [1:0] done_err = 2'd0;
   logic done_prst = 1'b0, prev_prst = 1'b0;
   bit   lock_en = 1;

   always @(negedge clk) begin
      if (pll_rst) prst_cnt++;
      if (prev_prst && !pll_rst) rst_fall_cyc = cyc;
      prev_prst = pll_rst;
      if (done) begin
         done_cnt++;
         done_cyc  = cyc;
         done_err  = err;
         done_prst = pll_rst;
      end
      if (rst || pll_rst) begin
         pll_locked = 1'b0;
         lk         = 0;
      end else if (lock_en) begin
         lk++;
         if (lk >= 20) pll_locked = 1'b1;
      end
   end

   int mcnt = 0;

   task automatic tick(input int n);
      repeat (n) begin
         @(negedge clk);
         #1;
      end
   endtask

   task automatic resync();
      for (int i = 0; i < 32; i++) shadow[i] = drp_mem[i];
      mcnt = 0;
   endtask

   task automatic push_op(input logic [4:0] a, input logic [15:0] m, input logic [15:0] d);
      logic [15:0] w;
      bit acc;
      chk("op_ready_before_push", 32'(op_ready), 32'(mcnt < 4));
      acc      = op_ready;
      op_valid = 1'b1;
      op_addr  = a;
      op_mask  = m;
      op_data  = d;
      tick(1);
      op_valid = 1'b0;
      if (acc) begin
         w         = (shadow[a] & m) | (d & ~m);
         shadow[a] = w;
         sb.push_back('{1'b0, a, 16'h0});
         sb.push_back('{1'b1, a, w});
         mcnt++;
      end
   endtask

   task automatic pulse_go(output int gc);
      go = 1'b1;
      tick(1);
      gc = cyc;
      go = 1'b0;
   endtask

   task automatic wait_done(input int bound, input string tag);
      int base, n;
      base = done_cnt;
      n    = 0;
      while (done_cnt == base && n < bound) begin
         tick(1);
         n++;
      end
      chk({tag, "_done_seen"}, 32'(done_cnt != base), 32'd1);
   endtask

   initial begin
      int base_den, base_prst, base_done, go_cyc, dummy, n;
      rst = 1'b1; op_valid = 1'b0; go = 1'b0;
      op_addr = 5'd0; op_mask = 16'h0; op_data = 16'h0;
      tick(3);
      chk("rst_op_ready", 32'(op_ready), 32'd1);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_err", 32'(err), 32'd0);
      chk("rst_pll_rst", 32'(pll_rst), 32'd0);
      chk("rst_drp", {drp_den, drp_dwe, drp_daddr, drp_di}, 32'd0);
      rst = 1'b0;
      tick(2);
      resync();

      // empty FIFO: plain PLL reset cycle
      base_den = den_count; base_prst = prst_cnt;
      pulse_go(go_cyc);
      chk("t1_busy", 32'(busy), 32'd1);
      chk("t1_pll_rst", 32'(pll_rst), 32'd1);
      wait_done(200, "t1");
      chk("t1_err", 32'(done_err), 32'd0);
      chk("t1_pll_rst_cycles", 32'(prst_cnt - base_prst), 32'(RST_HOLD));
      chk("t1_no_den", 32'(den_count - base_den), 32'd0);
      tick(2);

      // single RMW, 3-cycle DRDY
      push_op(5'h08, 16'hFF00, 16'h1234);
      drdy_lat = 3;
      base_den = den_count;
      pulse_go(go_cyc);
      wait_done(300, "t2");
      chk("t2_err", 32'(done_err), 32'd0);
      chk("t2_den_count", 32'(den_count - base_den), 32'd2);
      chk("t2_first_den_delay", 32'(den_cyc[base_den % 512] - go_cyc), 32'(RST_HOLD));
      chk("t2_wr_addr", 32'(last_wr_addr), 32'h08);
      chk("t2_wr_data", 32'(last_wr_data), 32'hAB34);
      chk("t2_sb_empty", 32'(sb.size()), 32'd0);
      mcnt = 0;
      tick(2);

      // fill the FIFO, run four operations in order
      drdy_lat = 1;
      push_op(5'h03, 16'h0000, 16'hC0DE);
      push_op(5'h1F, 16'hF0F0, 16'h1357);
      push_op(5'h08, 16'h00FF, 16'h5500);
      push_op(5'h10, 16'hFFFE, 16'hFFFF);
      chk("t3_full_ready", 32'(op_ready), 32'd0);
      push_op(5'h02, 16'h0000, 16'h0BAD);
      base_den = den_count;
      pulse_go(go_cyc);
      wait_done(400, "t3");
      chk("t3_err", 32'(done_err), 32'd0);
      chk("t3_den_count", 32'(den_count - base_den), 32'd8);
      chk("t3_sb_empty", 32'(sb.size()), 32'd0);
      tick(1);
      chk("t3_ready_after", 32'(op_ready), 32'd1);
      chk("t3_busy_after", 32'(busy), 32'd0);
      mcnt = 0;
      tick(2);

      // DRDY never arrives on the 2nd operation's read
      drdy_lat = 2;
      push_op(5'h01, 16'h0F0F, 16'hA5A5);
      push_op(5'h02, 16'h0000, 16'h1111);
      push_op(5'h04, 16'hFFFF, 16'h2222);
      base_den = den_count;
      stall_at = base_den + 2;
      pulse_go(go_cyc);
      wait_done(600, "t4");
      chk("t4_err", 32'(done_err), 32'd1);
      chk("t4_pll_rst_at_done", 32'(done_prst), 32'd0);
      chk("t4_abort_delay", 32'(done_cyc - den_cyc[(base_den + 2) % 512]), 32'(DRDY_TO + 1));
      chk("t4_sb_left", 32'(sb.size()), 32'd3);
      sb.delete();
      stall_at = -1;
      resync();
      tick(1);
      chk("t4_busy_after", 32'(busy), 32'd0);
      chk("t4_ready_after", 32'(op_ready), 32'd1);
      base_den = den_count;
      pulse_go(go_cyc);
      wait_done(200, "t4_flushed");
      chk("t4_flushed_err", 32'(done_err), 32'd0);
      chk("t4_flushed_no_den", 32'(den_count - base_den), 32'd0);
      tick(2);

      // lock never arrives; a second go while busy is ignored
      lock_en = 0;
      pulse_go(go_cyc);
      tick(3);
      pulse_go(dummy);
      chk("t5_busy", 32'(busy), 32'd1);
      wait_done(300, "t5");
      chk("t5_err", 32'(done_err), 32'd2);
      chk("t5_lock_timeout", 32'(done_cyc - rst_fall_cyc), 32'(LOCK_TO));
      base_done = done_cnt;
      tick(40);
      chk("t5_no_restart", 32'(done_cnt - base_done), 32'd0);
      chk("t5_idle", 32'(busy), 32'd0);
      chk("t5_err_held", 32'(err), 32'd2);
      lock_en = 1;

      // asynchronous reset in RD_WAIT
      push_op(5'h05, 16'h00FF, 16'hBEEF);
      drdy_lat = 20;
      base_den = den_count;
      pulse_go(go_cyc);
      n = 0;
      while (den_count == base_den && n < 50) begin
         tick(1);
         n++;
      end
      chk("t6_den_seen", 32'(den_count - base_den), 32'd1);
      tick(2);
      rst = 1'b1;
      #1;
      chk("t6_busy", 32'(busy), 32'd0);
      chk("t6_pll_rst", 32'(pll_rst), 32'd0);
      chk("t6_op_ready", 32'(op_ready), 32'd1);
      chk("t6_drp", {drp_den, drp_dwe, drp_daddr, drp_di}, 32'd0);
      chk("t6_done_err", {done, err}, 32'd0);
      tick(1);
      rst = 1'b0;
      sb.delete();
      resync();
      tick(2);
      base_den = den_count;
      pulse_go(go_cyc);
      wait_done(200, "t6_after");
      chk("t6_after_err", 32'(done_err), 32'd0);
      chk("t6_after_no_den", 32'(den_count - base_den), 32'd0);
      tick(2);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
`default_nettype wire
